id_ex_stage: RTL and testbench

- ID/EX pipeline stage of the 5-stage MIPS core, directly downstream of the register file.
- Captures decoded control, the register read operands (rs/rt data), the immediate and the destination register into the EX-side pipeline register.
- Detects load-use hazards against the instruction currently in EX and drives stall/bubble back to IF/ID, PC and the register file.
- Handles branch flush from EX and keeps a saturating stall-cycle counter.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/id_ex_stage_if.sv | 68 ++++++
 rtl/id_ex_stage_load_use_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 110 +++++++++++
 tb/tb_id_ex_stage.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline.
// Holds the ALU operation encoding, the ID/EX control bundle and small helpers
// that several pipeline stages rely on.
package mips_pkg;

    localparam int REG_ADDR_W = 5;

    // ALU control encoding as produced by the decoder
    typedef enum logic [3:0] {
        ALU_AND  = 4'h0,
        ALU_OR   = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SLL  = 4'h3,
        ALU_SRL  = 4'h4,
        ALU_SRA  = 4'h5,
        ALU_SUB  = 4'h6,
        ALU_SLT  = 4'h7,
        ALU_XOR  = 4'h8,
        ALU_LUI  = 4'h9,
        ALU_SLTU = 4'hA,
        ALU_NOR  = 4'hC
    } alu_op_t;

    // Control bits that travel from ID into EX
    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
    } id_ex_ctrl_t;

    // A bubble carries no side effects: every control bit cleared
    localparam id_ex_ctrl_t CTRL_BUBBLE = '{
        alu_op:     ALU_AND,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0
    };

    // R-type instructions write rd, I-type instructions write rt
    function automatic logic [REG_ADDR_W-1:0] resolve_dest(
        input logic                  reg_dst,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rt
    );
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX pipeline register and EX.
// The master modport is the pipeline stage itself; the slave modport is the
// surrounding core (decoder, register file, hazard consumers, EX stage).
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    import mips_pkg::*;

    logic                  id_valid;
    logic [DATA_W-1:0]     id_pc;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_uses_rt;
    logic [DATA_W-1:0]     id_rs_data;
    logic [DATA_W-1:0]     id_rt_data;
    logic [DATA_W-1:0]     id_imm;
    logic [3:0]            id_alu_op;
    logic                  id_alu_src;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  id_reg_write;
    logic                  id_mem_to_reg;
    logic                  id_reg_dst;
    logic                  flush;

    logic                  stall;
    logic                  bubble;
    logic                  ex_valid;
    logic [DATA_W-1:0]     ex_pc;
    logic [DATA_W-1:0]     ex_rs_data;
    logic [DATA_W-1:0]     ex_rt_data;
    logic [DATA_W-1:0]     ex_imm;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic [3:0]            ex_alu_op;
    logic                  ex_alu_src;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic                  ex_reg_write;
    logic                  ex_mem_to_reg;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_alu_op, id_alu_src,
               id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
               id_reg_dst, flush,
        output stall, bubble, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
               stall_count
    );

    modport slave (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_uses_rt,
               id_rs_data, id_rt_data, id_imm, id_alu_op, id_alu_src,
               id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
               id_reg_dst, flush,
        input  stall, bubble, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
               ex_imm, ex_rs, ex_rt, ex_dest, ex_alu_op, ex_alu_src,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg,
               stall_count
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that needs a register
// the load currently in EX has not yet fetched from memory.
// Register 0 is hardwired, so a load targeting it never causes a hazard.
module load_use_detect
    import mips_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  haz
);

    logic rs_match;
    logic rt_match;

    // Compare the pending load destination against each ID source operand
    always_comb begin
        rs_match = (ex_dest == id_rs);
        rt_match = id_uses_rt && (ex_dest == id_rt);
        haz      = id_valid && ex_valid && ex_mem_read &&
                   (ex_dest != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Captures decoded controls and operands for EX, inserts a bubble on a branch
// flush or a load-use stall, and counts stall cycles with saturation.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    id_ex_stage_if.master bus
);

    logic                  haz;
    logic                  stall_int;
    id_ex_ctrl_t           id_ctrl;
    id_ex_ctrl_t           ex_ctrl;
    logic                  ex_valid_q;
    logic [DATA_W-1:0]     ex_pc_q;
    logic [DATA_W-1:0]     ex_rs_data_q;
    logic [DATA_W-1:0]     ex_rt_data_q;
    logic [DATA_W-1:0]     ex_imm_q;
    logic [REG_ADDR_W-1:0] ex_rs_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    logic [REG_ADDR_W-1:0] ex_dest_q;
    logic [CNT_W-1:0]      stall_count_q;

    load_use_detect u_load_use_detect (
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_dest     (ex_dest_q),
        .haz         (haz)
    );

    // Pack decoder controls and resolve stall; a flush outranks the hazard
    // because the dependent instruction is being discarded anyway
    always_comb begin
        id_ctrl = '{
            alu_op:     alu_op_t'(bus.id_alu_op),
            alu_src:    bus.id_alu_src,
            mem_read:   bus.id_mem_read,
            mem_write:  bus.id_mem_write,
            reg_write:  bus.id_reg_write,
            mem_to_reg: bus.id_mem_to_reg
        };
        stall_int = haz && !bus.flush && reset_n;
    end

    // Pipeline register: bubble on flush or stall (data held), otherwise
    // capture ID; an invalid ID slot never carries live controls into EX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl      <= CTRL_BUBBLE;
            ex_pc_q      <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_dest_q    <= '0;
        end else if (bus.flush || stall_int) begin
            ex_valid_q <= 1'b0;
            ex_ctrl    <= CTRL_BUBBLE;
        end else begin
            ex_valid_q   <= bus.id_valid;
            ex_ctrl      <= bus.id_valid ? id_ctrl : CTRL_BUBBLE;
            ex_pc_q      <= bus.id_pc;
            ex_rs_data_q <= bus.id_rs_data;
            ex_rt_data_q <= bus.id_rt_data;
            ex_imm_q     <= bus.id_imm;
            ex_rs_q      <= bus.id_rs;
            ex_rt_q      <= bus.id_rt;
            ex_dest_q    <= resolve_dest(bus.id_reg_dst, bus.id_rd, bus.id_rt);
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_q <= '0;
        end else if (stall_int && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    assign bus.stall         = stall_int;
    assign bus.bubble        = stall_int;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_rs_data    = ex_rs_data_q;
    assign bus.ex_rt_data    = ex_rt_data_q;
    assign bus.ex_imm        = ex_imm_q;
    assign bus.ex_rs         = ex_rs_q;
    assign bus.ex_rt         = ex_rt_q;
    assign bus.ex_dest       = ex_dest_q;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, capture, load-use stall,
// false-stall cases, NOP capture, flush priority, counter saturation
// (4-bit counter) and asynchronous reset in the middle of a stall.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic clk;
    logic reset_n;
    int   compared;
    int   mismatched;

    id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] pc,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic uses_rt,
                                  input logic reg_dst, input logic mem_read,
                                  input logic reg_write, input logic mem_to_reg,
                                  input logic alu_src, input logic [3:0] alu_op);
        bus.id_valid      = valid;
        bus.id_pc         = pc;
        bus.id_rs         = rs;
        bus.id_rt         = rt;
        bus.id_rd         = rd;
        bus.id_uses_rt    = uses_rt;
        bus.id_rs_data    = pc ^ 32'hA000_0000;
        bus.id_rt_data    = pc ^ 32'h0B00_0000;
        bus.id_imm        = {16'h0, pc[15:0]};
        bus.id_alu_op     = alu_op;
        bus.id_alu_src    = alu_src;
        bus.id_mem_read   = mem_read;
        bus.id_mem_write  = 1'b0;
        bus.id_reg_write  = reg_write;
        bus.id_mem_to_reg = mem_to_reg;
        bus.id_reg_dst    = reg_dst;
    endtask

    task automatic drive_lw(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt);
        apply_stimulus(1'b1, pc, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2);
    endtask

    task automatic drive_rtype(input logic [31:0] pc, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd);
        apply_stimulus(1'b1, pc, rs, rt, rd, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2);
    endtask

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clk        = 1'b0;
        reset_n    = 1'b1;
        bus.flush  = 1'b0;
        apply_stimulus(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                       1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'($urandom));
        #3;
        reset_n = 1'b0;
        #1;
        check_output("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check_output("rst_stall", 32'(bus.stall), 32'd0);
        check_output("rst_count", 32'(bus.stall_count), 32'd0);
        tick();
        check_output("rst_edge_ex_pc", bus.ex_pc, 32'd0);
        check_output("rst_edge_ex_dest", 32'(bus.ex_dest), 32'd0);
        check_output("rst_edge_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check_output("rst_edge_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check_output("rst_edge_alu_op", 32'(bus.ex_alu_op), 32'd0);
        check_output("rst_edge_bubble", 32'(bus.bubble), 32'd0);

        // ADD r3 = r1 + r2
        reset_n = 1'b1;
        drive_rtype(32'h100, 5'd1, 5'd2, 5'd3);
        tick();
        check_output("add_ex_valid", 32'(bus.ex_valid), 32'd1);
        check_output("add_ex_dest", 32'(bus.ex_dest), 32'd3);
        check_output("add_reg_write", 32'(bus.ex_reg_write), 32'd1);
        check_output("add_ex_pc", bus.ex_pc, 32'h100);
        check_output("add_rs_data", bus.ex_rs_data, 32'hA000_0100);
        check_output("add_rt_data", bus.ex_rt_data, 32'h0B00_0100);
        check_output("add_imm", bus.ex_imm, 32'h100);
        check_output("add_ex_rs", 32'(bus.ex_rs), 32'd1);
        check_output("add_alu_op", 32'(bus.ex_alu_op), 32'd2);

        // LW r5, then dependent ADD r7 = r5 + r6
        drive_lw(32'h104, 5'd1, 5'd5);
        #1;
        check_output("lw_no_stall", 32'(bus.stall), 32'd0);
        tick();
        check_output("lw_ex_dest", 32'(bus.ex_dest), 32'd5);
        check_output("lw_mem_read", 32'(bus.ex_mem_read), 32'd1);
        check_output("lw_mem_to_reg", 32'(bus.ex_mem_to_reg), 32'd1);
        drive_rtype(32'h108, 5'd5, 5'd6, 5'd7);
        #1;
        check_output("lu_stall", 32'(bus.stall), 32'd1);
        check_output("lu_bubble", 32'(bus.bubble), 32'd1);
        tick();
        check_output("lu_bub_valid", 32'(bus.ex_valid), 32'd0);
        check_output("lu_bub_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check_output("lu_bub_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check_output("lu_bub_alu_op", 32'(bus.ex_alu_op), 32'd0);
        check_output("lu_bub_pc_held", bus.ex_pc, 32'h104);
        check_output("lu_count", 32'(bus.stall_count), 32'd1);
        check_output("lu_stall_clear", 32'(bus.stall), 32'd0);
        tick();
        check_output("lu_cap_valid", 32'(bus.ex_valid), 32'd1);
        check_output("lu_cap_pc", bus.ex_pc, 32'h108);
        check_output("lu_cap_dest", 32'(bus.ex_dest), 32'd7);
        check_output("lu_cap_count", 32'(bus.stall_count), 32'd1);

        // LW r5 followed by an I-type that does not read rt
        drive_lw(32'h10C, 5'd1, 5'd5);
        tick();
        apply_stimulus(1'b1, 32'h110, 5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h2);
        #1;
        check_output("nouse_rt_stall", 32'(bus.stall), 32'd0);
        tick();
        check_output("nouse_rt_dest", 32'(bus.ex_dest), 32'd5);

        // LW to r0 followed by a reader of r0
        drive_lw(32'h114, 5'd2, 5'd0);
        tick();
        check_output("lw0_dest", 32'(bus.ex_dest), 32'd0);
        check_output("lw0_mem_read", 32'(bus.ex_mem_read), 32'd1);
        drive_rtype(32'h118, 5'd0, 5'd0, 5'd8);
        #1;
        check_output("r0_stall", 32'(bus.stall), 32'd0);
        tick();
        check_output("r0_cap_valid", 32'(bus.ex_valid), 32'd1);
        check_output("r0_count", 32'(bus.stall_count), 32'd1);

        // Invalid ID slot: fields captured, controls forced off
        apply_stimulus(1'b0, 32'h200, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h6);
        tick();
        check_output("nop_valid", 32'(bus.ex_valid), 32'd0);
        check_output("nop_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check_output("nop_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check_output("nop_alu_op", 32'(bus.ex_alu_op), 32'd0);
        check_output("nop_pc", bus.ex_pc, 32'h200);
        check_output("nop_dest", 32'(bus.ex_dest), 32'd9);

        // Hazard and flush together: flush wins
        drive_lw(32'h120, 5'd1, 5'd5);
        tick();
        drive_rtype(32'h124, 5'd5, 5'd6, 5'd7);
        bus.flush = 1'b1;
        #1;
        check_output("fl_stall", 32'(bus.stall), 32'd0);
        check_output("fl_bubble", 32'(bus.bubble), 32'd0);
        tick();
        bus.flush = 1'b0;
        check_output("fl_valid", 32'(bus.ex_valid), 32'd0);
        check_output("fl_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check_output("fl_count", 32'(bus.stall_count), 32'd1);
        check_output("fl_pc_held", bus.ex_pc, 32'h120);

        // Twenty load-use stalls: counter stops at 15
        for (int i = 0; i < 20; i++) begin
            drive_lw(32'h400 + 32'(i * 8), 5'd1, 5'd5);
            tick();
            drive_rtype(32'h404 + 32'(i * 8), 5'd5, 5'd6, 5'd7);
            #1;
            check_output("sat_stall", 32'(bus.stall), 32'd1);
            tick();
        end
        check_output("sat_count", 32'(bus.stall_count), 32'd15);

        // Asynchronous reset while stalling, then normal capture
        drive_lw(32'h300, 5'd1, 5'd5);
        tick();
        drive_rtype(32'h304, 5'd5, 5'd6, 5'd7);
        #1;
        check_output("ar_stall_before", 32'(bus.stall), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("ar_valid", 32'(bus.ex_valid), 32'd0);
        check_output("ar_pc", bus.ex_pc, 32'd0);
        check_output("ar_dest", 32'(bus.ex_dest), 32'd0);
        check_output("ar_mem_read", 32'(bus.ex_mem_read), 32'd0);
        check_output("ar_stall", 32'(bus.stall), 32'd0);
        check_output("ar_count", 32'(bus.stall_count), 32'd0);
        #1;
        reset_n = 1'b1;
        #1;
        check_output("ar_rel_stall", 32'(bus.stall), 32'd0);
        tick();
        check_output("ar_cap_valid", 32'(bus.ex_valid), 32'd1);
        check_output("ar_cap_pc", bus.ex_pc, 32'h304);
        check_output("ar_cap_dest", 32'(bus.ex_dest), 32'd7);
        check_output("ar_cap_reg_write", 32'(bus.ex_reg_write), 32'd1);
        check_output("ar_cap_count", 32'(bus.stall_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
